// File: rtl/aes_encipher_core.sv
// Purpose : iterative AES-128/192/256 encryption, one round per clock, round keys from an external store.
// Latency : result held 12/14/16 cycles after accept (AES-128/192/256); unsupported keylen reports after 1 cycle.
// Backpr. : result held in DONE until out_ready; a new block can be taken on the same edge the result leaves.
// Ports   : in_valid/in_ready/in_block/in_keylen  - block offer (keylen 00=128, 01=192, 10=256, 11=reserved)
//           round_idx -> round_key                - combinational lookup into the caller's key store
//           out_valid/out_ready/out_block/out_err - result handshake; out_err flags an unsupported keylen
//           busy                                  - core is not idle
module aes_encipher_core #(
  parameter bit EN_AES192 = 1'b1,
  parameter bit EN_AES256 = 1'b1,
  parameter int KEYLEN_W  = 2      // keylen field width; only 2 is meaningful
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_block,
  input  logic [KEYLEN_W-1:0] in_keylen,
  output logic [3:0]          round_idx,
  input  logic [127:0]        round_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_block,
  output logic                out_err,
  output logic                busy
);

  // FIPS-197 forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_MAIN, S_FINAL, S_DONE} state_e;

  state_e       st_q, st_d;
  logic [127:0] blk_q, blk_d;   // AES state; holds the latched plaintext until INIT
  logic [3:0]   cnt_q, cnt_d;   // round counter
  logic [3:0]   nr_q, nr_d;     // number of rounds for the block in flight
  logic         err_q, err_d;
  logic         accept;
  logic         kl_ok;
  logic [3:0]   kl_nr;

  // Top byte of the table is entry 0, so entry b starts at bit 2047-8*b = {~b,3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes + ShiftRows. FIPS byte i = row + 4*col lives at bits [127-8i -: 8];
  // row r of the output takes column (c+r) mod 4 of the input.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = sbox(s[127-8*(row+4*((c+row)%4)) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  always_comb begin
    kl_ok = 1'b0;
    kl_nr = 4'd10;
    case (in_keylen)
      2'b00:   begin kl_ok = 1'b1;      kl_nr = 4'd10; end
      2'b01:   begin kl_ok = EN_AES192; kl_nr = 4'd12; end
      2'b10:   begin kl_ok = EN_AES256; kl_nr = 4'd14; end
      default: begin kl_ok = 1'b0;      kl_nr = 4'd10; end
    endcase
  end

  assign in_ready = (st_q == S_IDLE) || ((st_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    st_d      = st_q;
    blk_d     = blk_q;
    cnt_d     = cnt_q;
    nr_d      = nr_q;
    err_d     = err_q;
    round_idx = 4'd0;
    case (st_q)
      S_INIT: begin
        blk_d = blk_q ^ round_key;
        cnt_d = 4'd1;
        st_d  = S_MAIN;
      end
      S_MAIN: begin
        round_idx = cnt_q;
        blk_d     = mix_cols(sub_shift(blk_q)) ^ round_key;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == nr_q - 4'd1) st_d = S_FINAL;
      end
      S_FINAL: begin
        round_idx = nr_q;
        blk_d     = sub_shift(blk_q) ^ round_key;
        cnt_d     = 4'd0;
        st_d      = S_DONE;
      end
      S_DONE: begin
        if (out_ready) st_d = S_IDLE;
      end
      default: ;
    endcase
    // Accept only happens in IDLE or DONE, so it overrides the DONE->IDLE step.
    // An unsupported keylen skips the rounds and reports straight away with a zero block.
    if (accept) begin
      err_d = !kl_ok;
      nr_d  = kl_nr;
      cnt_d = 4'd0;
      blk_d = kl_ok ? in_block : '0;
      st_d  = kl_ok ? S_INIT : S_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= S_IDLE;
      blk_q <= '0;
      cnt_q <= 4'd0;
      nr_q  <= 4'd0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
      nr_q  <= nr_d;
      err_q <= err_d;
    end
  end

  assign out_valid = (st_q == S_DONE);
  assign out_err   = out_valid && err_q;
  assign out_block = (out_valid && !err_q) ? blk_q : '0;
  assign busy      = (st_q != S_IDLE);

endmodule

// File: tb/tb_aes_encipher_core.sv
// Purpose : directed bench for aes_encipher_core with a scoreboard of expected results and an independent key model.
// Latency : expected latency is counted in clock edges from the accept edge to the edge that can take the result.
// Backpr. : exercises held results under out_ready=0 and same-edge hand-over to the next block.
module tb_aes_encipher_core;

  localparam logic [255:0] KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY2  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT2   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [127:0] in_block, round_key, out_block;
  logic [1:0]   in_keylen;
  logic [3:0]   round_idx;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err, b_busy;
  logic [127:0] b_in_block, b_round_key, b_out_block;
  logic [1:0]   b_in_keylen;
  logic [3:0]   b_round_idx;

  aes_encipher_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .in_keylen(in_keylen), .round_idx(round_idx), .round_key(round_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .out_err(out_err), .busy(busy)
  );

  aes_encipher_core #(.EN_AES256(1'b0)) dut_no256 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_block(b_in_block),
    .in_keylen(b_in_keylen), .round_idx(b_round_idx), .round_key(b_round_key), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_block(b_out_block), .out_err(b_out_err), .busy(b_busy)
  );

  logic [7:0]   sb [0:255];
  logic [127:0] rk [0:14];

  assign round_key   = rk[round_idx];
  assign b_round_key = rk[b_round_idx];

  typedef struct {
    logic [127:0] blk;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse and the affine transform, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input logic [1:0] kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nw;
    nk = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [127:0] blk, input logic [1:0] kl, input logic [127:0] exp,
                      input logic err, input int lat);
    exp_t e;
    int   n;
    in_valid = 1'b1; in_block = blk; in_keylen = kl;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    check("accept_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    e.blk = exp; e.err = err; e.lat = lat;
    @(negedge clk);
    e.acc = cyc;
    sbq.push_back(e);
    in_valid = 1'b0;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    in_keylen = 2'b11;
  endtask

  // Waits for out_valid (bounded) and compares against the oldest expectation.
  task automatic collect();
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("queue_nonempty", 128'(sbq.size() != 0), 128'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("out_valid", 128'(out_valid), 128'd1);
      check("out_block", out_block, e.blk);
      check("out_err", 128'(out_err), 128'(e.err));
      check("latency", 128'(cyc - e.acc + 1), 128'(e.lat));
      check("done_round_idx", 128'(round_idx), 128'd0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_block = '0; in_keylen = 2'b00; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_block = '0; b_in_keylen = 2'b00; b_out_ready = 1'b1;
    build_sbox();
    expand(KEY, 2'b00);
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_block", out_block, 128'd0);
    check("rst_out_err", 128'(out_err), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_round_idx", 128'(round_idx), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer vectors for all three key lengths
    send(PT, 2'b00, CT128, 1'b0, 12); collect(); @(negedge clk);
    check("idle_after_128", 128'(busy), 128'd0);
    expand(KEY, 2'b01);
    send(PT, 2'b01, CT192, 1'b0, 14); collect(); @(negedge clk);
    expand(KEY, 2'b10);
    send(PT, 2'b10, CT256, 1'b0, 16); collect(); @(negedge clk);
    check("idle_after_256", 128'(out_valid), 128'd0);

    // Backpressure, then same-edge hand-over to a second block with a different key
    expand(KEY, 2'b00);
    out_ready = 1'b0;
    send(PT, 2'b00, CT128, 1'b0, 12); collect();
    in_valid = 1'b1; in_block = PT2; in_keylen = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_block", out_block, CT128);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    expand(KEY2, 2'b00);
    out_ready = 1'b1;
    send(PT2, 2'b00, CT2, 1'b0, 12);
    check("b2b_out_valid", 128'(out_valid), 128'd0);
    check("b2b_busy", 128'(busy), 128'd1);
    collect(); @(negedge clk);

    // Unsupported keylen: reserved code, and AES-256 on a core built without it
    send(PT, 2'b11, 128'd0, 1'b1, 1); collect(); @(negedge clk);
    b_in_valid = 1'b1; b_in_block = PT; b_in_keylen = 2'b10;
    check("no256_in_ready", 128'(b_in_ready), 128'd1);
    @(negedge clk);
    b_in_valid = 1'b0;
    check("no256_out_valid", 128'(b_out_valid), 128'd1);
    check("no256_out_err", 128'(b_out_err), 128'd1);
    check("no256_out_block", b_out_block, 128'd0);
    @(negedge clk);
    check("no256_consumed", 128'(b_out_valid), 128'd0);

    // Reset in the middle of round 5 aborts without output
    expand(KEY, 2'b00);
    send(PT, 2'b00, CT128, 1'b0, 12);
    n = 0;
    while (round_idx != 4'd5 && n < 40) begin @(negedge clk); n++; end
    check("abort_at_round5", 128'(round_idx), 128'd5);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_out_block", out_block, 128'd0);
    check("abort_out_err", 128'(out_err), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_round_idx", 128'(round_idx), 128'd0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 128'(in_ready), 128'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("abort_no_output", 128'(n), 128'd0);
    send(PT, 2'b00, CT128, 1'b0, 12); collect(); @(negedge clk);

    // in_valid toggling with junk while busy must be ignored
    expand(KEY, 2'b01);
    send(PT, 2'b01, CT192, 1'b0, 14);
    for (int i = 0; i < 8; i++) begin
      check("busy_in_ready", 128'(in_ready), 128'd0);
      in_valid  = (i % 2 == 0);
      in_block  = {$urandom, $urandom, $urandom, $urandom};
      in_keylen = 2'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect(); @(negedge clk);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    check("toggle_no_extra", 128'(n), 128'd0);
    check("queue_drained", 128'(sbq.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
